// File: rtl/prog_stream_loader.sv
// Byte-stream program loader: turns a length-prefixed byte stream into imem line and dmem word writes.
// Optional trailing checksum byte enabled with `define LOADER_CHECKSUM_EN.
module prog_stream_loader #(
    parameter int unsigned ADDR_LEN  = 32,
    parameter logic [31:0] IMEM_BASE = 32'h0,
    parameter logic [31:0] DMEM_BASE = 32'h0
) (
    input  logic                clk,
    input  logic                reset_x,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [ADDR_LEN-1:0] load_addr,
    output logic [127:0]        load_data,
    output logic                we_32,
    output logic                we_128,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        IMEM_LEN,
        IMEM_DATA,
        DMEM_LEN,
        DMEM_DATA,
        CHECK,
        DONE
    } state_e;

    localparam logic [ADDR_LEN-1:0] IBASE = ADDR_LEN'(IMEM_BASE);
    localparam logic [ADDR_LEN-1:0] DBASE = ADDR_LEN'(DMEM_BASE);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e END_ST = CHECK;
`else
    localparam state_e END_ST = DONE;
`endif

    state_e                state_q, state_d;
    logic [31:0]           len_q, len_d;
    logic [1:0]            len_cnt_q, len_cnt_d;
    logic [31:0]           rem_q, rem_d;
    logic [3:0]            pos_q, pos_d;
    logic [127:0]          buf_q, buf_d;
    logic [ADDR_LEN-1:0]   idx_q, idx_d;
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [127:0]          data_q, data_d;
    logic                  we32_q, we32_d;
    logic                  we128_q, we128_d;
    logic                  done_q, done_d;

    logic [31:0]           full_len;
    logic [127:0]          byte_line;
    logic                  last_byte;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
    logic                  err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        len_cnt_d = len_cnt_q;
        rem_d     = rem_q;
        pos_d     = pos_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we32_d    = 1'b0;
        we128_d   = 1'b0;
        done_d    = done_q | (state_q == DONE);
`ifdef LOADER_CHECKSUM_EN
        err_d     = err_q;
`endif
        full_len  = {rx_data, len_q[31:8]};
        last_byte = (rem_q == 32'd1);
        // Word w of a line sits at bits 32*(3-w); byte b of a word at 8*b.
        byte_line = buf_q;
        byte_line[{~pos_q[3:2], pos_q[1:0], 3'b000} +: 8] = rx_data;

        if (rx_valid) begin
            unique case (state_q)
                IMEM_LEN, DMEM_LEN: begin
                    len_d     = full_len;
                    len_cnt_d = len_cnt_q + 2'd1;
                    if (len_cnt_q == 2'd3) begin
                        rem_d = full_len;
                        idx_d = '0;
                        pos_d = '0;
                        buf_d = '0;
                        if (state_q == IMEM_LEN) begin
                            state_d = (full_len == '0) ? DMEM_LEN : IMEM_DATA;
                        end else if (full_len != '0) begin
                            state_d = DMEM_DATA;
                        end else begin
                            state_d = END_ST;
                            if (END_ST == DONE) done_d = 1'b1;
                        end
                    end
                end
                IMEM_DATA: begin
                    buf_d = byte_line;
                    pos_d = pos_q + 4'd1;
                    rem_d = rem_q - 32'd1;
                    if (pos_q == 4'hf || last_byte) begin
                        we128_d = 1'b1;
                        data_d  = byte_line;
                        addr_d  = IBASE + (idx_q << 4);
                        idx_d   = idx_q + 1'b1;
                        buf_d   = '0;
                        pos_d   = '0;
                    end
                    if (last_byte) state_d = DMEM_LEN;
                end
                DMEM_DATA: begin
                    buf_d = byte_line;
                    pos_d = pos_q + 4'd1;
                    rem_d = rem_q - 32'd1;
                    if (pos_q[1:0] == 2'd3 || last_byte) begin
                        we32_d = 1'b1;
                        data_d = {byte_line[127:96], 96'b0};
                        addr_d = DBASE + (idx_q << 2);
                        idx_d  = idx_q + 1'b1;
                        buf_d  = '0;
                        pos_d  = '0;
                    end
                    if (last_byte) state_d = END_ST;
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    err_d   = err_q | (rx_data != sum_q);
                    state_d = DONE;
                    done_d  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_comb begin
        sum_d = sum_q;
        if (rx_valid && (state_q == IMEM_LEN || state_q == IMEM_DATA ||
                         state_q == DMEM_LEN || state_q == DMEM_DATA)) begin
            sum_d = sum_q + rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q   <= IMEM_LEN;
            len_q     <= '0;
            len_cnt_q <= '0;
            rem_q     <= '0;
            pos_q     <= '0;
            buf_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we32_q    <= 1'b0;
            we128_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            len_cnt_q <= len_cnt_d;
            rem_q     <= rem_d;
            pos_q     <= pos_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we32_q    <= we32_d;
            we128_q   <= we128_d;
            done_q    <= done_d;
        end
    end

    assign load_addr = addr_q;
    assign load_data = data_q;
    assign we_32     = we32_q;
    assign we_128    = we128_q;
    assign done      = done_q;

endmodule

// File: tb/tb_prog_stream_loader.sv
// Directed bench for prog_stream_loader: line/word assembly, partial writes, reset abort, done/err.
// Checksum vectors are exercised when LOADER_CHECKSUM_EN is defined.
module tb_prog_stream_loader;

    logic         clk = 1'b0;
    logic         reset_x;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [31:0]  load_addr;
    logic [127:0] load_data;
    logic         we_32;
    logic         we_128;
    logic         done;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic         line;
        logic [31:0]  addr;
        logic [127:0] data;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] qi[$];
    logic [7:0] qd[$];

    prog_stream_loader dut (
        .clk       (clk),
        .reset_x   (reset_x),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .load_addr (load_addr),
        .load_data (load_data),
        .we_32     (we_32),
        .we_128    (we_128),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we_32 && we_128) check("excl", 1, 0);
        if (we_32 || we_128) ev_q.push_back('{we_128, load_addr, load_data});
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_x = 1'b0;
        repeat (2) @(negedge clk);
        reset_x = 1'b1;
        ev_q.delete();
    endtask

    task automatic load(input logic [7:0] im[$], input logic [7:0] dm[$]);
        logic [31:0] n;
        logic [7:0]  s;
        s = '0;
        n = im.size();
        for (int i = 0; i < 4; i++) begin send(n[8*i +: 8]); s += n[8*i +: 8]; end
        foreach (im[i]) begin send(im[i]); s += im[i]; end
        n = dm.size();
        for (int i = 0; i < 4; i++) begin send(n[8*i +: 8]); s += n[8*i +: 8]; end
        foreach (dm[i]) begin send(dm[i]); s += dm[i]; end
`ifdef LOADER_CHECKSUM_EN
        send(s);
`endif
        idle();
    endtask

    task automatic check_ev(input string tag, input int i, input logic line,
                            input logic [31:0] addr, input logic [127:0] data);
        if (i >= ev_q.size()) begin
            check({tag, "_missing"}, 0, 1);
        end else begin
            check({tag, "_kind"}, ev_q[i].line, line);
            check({tag, "_addr"}, ev_q[i].addr, addr);
            check({tag, "_data"}, ev_q[i].data, data);
        end
    endtask

    initial begin
        reset_x  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_we32", we_32, 0);
        check("rst_we128", we_128, 0);
        check("rst_addr", load_addr, 0);
        check("rst_data", load_data, 0);
        reset_x = 1'b1;

        // Full single line, no dmem
        qi.delete(); qd.delete();
        for (int i = 0; i < 16; i++) qi.push_back(8'(i));
        load(qi, qd);
        repeat (3) @(negedge clk);
        check("t1_nev", ev_q.size(), 1);
        check_ev("t1_l0", 0, 1'b1, 32'h0, 128'h03020100_07060504_0B0A0908_0F0E0D0C);
        check("t1_done", done, 1);
        check("t1_hold", load_data, 128'h03020100_07060504_0B0A0908_0F0E0D0C);
        check("t1_we128_low", we_128, 0);

        // dmem only, two words, done timing
        do_reset();
        qi.delete(); qd.delete();
        qd = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load(qi, qd);
`ifndef LOADER_CHECKSUM_EN
        check("t2_we32_last", we_32, 1);
        check("t2_done_early", done, 0);
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_we32_off", we_32, 0);
`endif
        repeat (2) @(negedge clk);
        check("t2_nev", ev_q.size(), 2);
        check_ev("t2_w0", 0, 1'b0, 32'h0, {32'h00000013, 96'h0});
        check_ev("t2_w1", 1, 1'b0, 32'h4, {32'hDEADBEEF, 96'h0});
        check("t2_done_hold", done, 1);

        // Partial imem line
        do_reset();
        qi.delete(); qd.delete();
        for (int i = 0; i < 6; i++) qi.push_back(8'(8'h11 + i));
        load(qi, qd);
        repeat (3) @(negedge clk);
        check("t3_nev", ev_q.size(), 1);
        check_ev("t3_l0", 0, 1'b1, 32'h0, {32'h14131211, 32'h00001615, 64'h0});
        check("t3_done", done, 1);

        // Two lines plus partial dmem word
        do_reset();
        qi.delete(); qd.delete();
        for (int i = 0; i < 20; i++) qi.push_back(8'(8'h20 + i));
        qd = '{8'hA1, 8'hA2, 8'hA3};
        load(qi, qd);
        repeat (3) @(negedge clk);
        check("t4_nev", ev_q.size(), 3);
        check_ev("t4_l0", 0, 1'b1, 32'h0, 128'h23222120_27262524_2B2A2928_2F2E2D2C);
        check_ev("t4_l1", 1, 1'b1, 32'h10, {32'h33323130, 96'h0});
        check_ev("t4_w0", 2, 1'b0, 32'h0, {32'h00A3A2A1, 96'h0});
        check("t4_done", done, 1);

        // Reset after 10 of 16 imem bytes, then restart
        do_reset();
        send(8'h10); send(8'h00); send(8'h00); send(8'h00);
        for (int i = 0; i < 10; i++) send(8'(i));
        @(negedge clk);
        rx_valid = 1'b0;
        #2 reset_x = 1'b0;
        #1;
        check("t5_nev_pre", ev_q.size(), 0);
        check("t5_rst_we128", we_128, 0);
        check("t5_rst_done", done, 0);
        repeat (2) @(negedge clk);
        check("t5_nev_rst", ev_q.size(), 0);
        reset_x = 1'b1;
        qi.delete(); qd.delete();
        for (int i = 0; i < 16; i++) qi.push_back(8'(i));
        load(qi, qd);
        repeat (3) @(negedge clk);
        check("t5_nev", ev_q.size(), 1);
        check_ev("t5_l0", 0, 1'b1, 32'h0, 128'h03020100_07060504_0B0A0908_0F0E0D0C);

        // Both lengths zero, then extra bytes ignored
        do_reset();
        qi.delete(); qd.delete();
        load(qi, qd);
        check("t6_done_now", done, 1);
        repeat (2) @(negedge clk);
        check("t6_nev", ev_q.size(), 0);
        for (int i = 0; i < 4; i++) send(8'hAA);
        idle();
        repeat (2) @(negedge clk);
        check("t6_nev_extra", ev_q.size(), 0);
        check("t6_done_hold", done, 1);
        check("t6_addr", load_addr, 0);
        check("t6_data", load_data, 0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        foreach (qi[i]) qi.delete();
        qi.delete(); qd.delete();
        send(8'h04); send(8'h00); send(8'h00); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        send(8'h0E);
        idle();
        repeat (2) @(negedge clk);
        check("ck_ok_done", done, 1);
        check("ck_ok_err", err, 0);
        check("ck_ok_nev", ev_q.size(), 1);

        do_reset();
        send(8'h04); send(8'h00); send(8'h00); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        send(8'h0F);
        idle();
        repeat (2) @(negedge clk);
        check("ck_bad_done", done, 1);
        check("ck_bad_err", err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
